aer_stream_tx: RTL and testbench

Parametrised AER transmitter, successor to the single-shot image sender. Streams a programmable number of addresses from an external event buffer onto a 4-phase REQ/ACK AER link. Adds a start/done command interface, a synchronous buffer read port instead of a full-array input, a configurable ACK synchroniser depth, an inter-event gap, a handshake timeout and abort. Sits between the controller/sorter and the off-chip or neighbouring-core AER input.

---
 rtl/aer_stream_tx.sv | 197 +++++++++++++++++++
 tb/tb_aer_stream_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_stream_tx.sv
// rtl/aer_stream_tx.sv - AER burst transmitter: event buffer reads onto a 4-phase REQ/ACK link
module aer_stream_tx #(
    parameter int M           = 8,
    parameter int DEPTH       = 256,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 0,
    parameter int TIMEOUT     = 1023,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW:0]   num_events_i,
    input  logic          abort_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [M-1:0]  rd_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_err_o,
    output logic [AW:0]   evt_cnt_o,
    output logic [M-1:0]  aerout_addr_o,
    output logic          aerout_req_o,
    input  logic          aerout_ack_i
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AW:0]   ONE      = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_REQ, S_RELEASE, S_GAP, S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [AW:0]            num_q;
    // evt_cnt_q doubles as the buffer index: both start at 0 and advance together
    logic [AW:0]            evt_cnt_q;
    logic [M-1:0]           aerout_addr_q;
    logic                   aerout_req_q;
    logic                   busy_q;
    logic                   timeout_err_q;
    logic                   abort_q;
    logic [GW-1:0]          gap_q;
    logic [TW-1:0]          tcnt_q;

    logic ack_s;
    logic abort_any;
    logic last_evt;
    logic timeout_hit;

    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign abort_any   = abort_i | abort_q;
    assign last_evt    = ((evt_cnt_q + ONE) == num_q);
    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TO_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (num_events_i == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_REQ;
            S_REQ: begin
                if (ack_s) begin
                    state_d = S_RELEASE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!ack_s) begin
                    if (abort_any || last_evt) begin
                        state_d = S_FINISH;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort_any) begin
                    state_d = S_FINISH;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_FETCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded directly from state
    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        done_o    = 1'b0;
        if (state_q == S_FETCH) begin
            rd_en_o   = 1'b1;
            rd_addr_o = evt_cnt_q[AW-1:0];
        end
        if (state_q == S_FINISH) begin
            done_o = 1'b1;
        end
    end

    // Datapath: ACK synchroniser, counters, AER outputs and status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q        <= '0;
            num_q         <= '0;
            evt_cnt_q     <= '0;
            aerout_addr_q <= '0;
            aerout_req_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            abort_q       <= 1'b0;
            gap_q         <= '0;
            tcnt_q        <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], aerout_ack_i};
            // Abort is remembered so a short pulse still ends the burst after the current handshake
            if (state_q != S_IDLE && abort_i) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        num_q         <= num_events_i;
                        evt_cnt_q     <= '0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                        abort_q       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    aerout_addr_q <= rd_data_i;
                    aerout_req_q  <= 1'b1;
                    tcnt_q        <= '0;
                end
                S_REQ: begin
                    if (ack_s) begin
                        aerout_req_q <= 1'b0;
                        tcnt_q       <= '0;
                    end else if (timeout_hit) begin
                        aerout_req_q  <= 1'b0;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!ack_s) begin
                        evt_cnt_q <= evt_cnt_q + ONE;
                        gap_q     <= '0;
                    end else if (timeout_hit) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_GAP:    gap_q  <= gap_q + GW'(1);
                S_FINISH: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign timeout_err_o = timeout_err_q;
    assign evt_cnt_o     = evt_cnt_q;
    assign aerout_addr_o = aerout_addr_q;
    assign aerout_req_o  = aerout_req_q;

endmodule

// File: tb/tb_aer_stream_tx.sv
// tb/tb_aer_stream_tx.sv - scoreboard bench for aer_stream_tx
module tb_aer_stream_tx;

    localparam int M       = 8;
    localparam int DEPTH   = 8;
    localparam int SYNC    = 2;
    localparam int GAP     = 4;
    localparam int TMO     = 16;
    localparam int AW      = 3;
    localparam int ACK_DLY = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ack = 1'b0;
    logic [AW:0]   num = '0;
    logic          rd_en, busy, done, terr, req;
    logic [AW-1:0] rd_addr;
    logic [M-1:0]  rd_data = '0;
    logic [M-1:0]  aer_addr;
    logic [AW:0]   evt_cnt;
    logic [M-1:0]  mem [DEPTH];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_addr[$];
    int exp_done[$];
    int start_cyc = 0;
    int done_lat = -1;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int req_rise_cyc = 0;
    int req_fall_cyc = 0;
    int rd_cnt = 0;
    int dly = 0;
    bit first_req = 1'b0;
    bit fall_valid = 1'b0;
    bit rise_valid = 1'b0;
    bit ack_en = 1'b1;
    logic req_prev = 1'b0;

    aer_stream_tx #(
        .M(M), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .start_i(start),
        .num_events_i(num),
        .abort_i(abort),
        .rd_en_o(rd_en),
        .rd_addr_o(rd_addr),
        .rd_data_i(rd_data),
        .busy_o(busy),
        .done_o(done),
        .timeout_err_o(terr),
        .evt_cnt_o(evt_cnt),
        .aerout_addr_o(aer_addr),
        .aerout_req_o(req),
        .aerout_ack_i(ack)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous event buffer: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // ACK responder with a fixed delay on both edges
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ack = 1'b0;
            dly = 0;
        end else if (ack_en && req && !ack) begin
            if (dly == ACK_DLY) begin
                ack = 1'b1; dly = 0; rise_cyc = cyc; rise_valid = 1'b1;
            end else dly++;
        end else if (!req && ack) begin
            if (dly == ACK_DLY) begin
                ack = 1'b0; dly = 0; fall_cyc = cyc; fall_valid = 1'b1;
            end else dly++;
        end else begin
            dly = 0;
        end
    end

    // Monitor: pops expected addresses on REQ rise, expected counts on DONE
    initial forever begin
        @(negedge clk);
        if (rd_en) rd_cnt++;
        if (req && !req_prev) begin
            req_rise_cyc = cyc;
            if (exp_addr.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL req_unexpected: got addr 0x%0h, expected no request", aer_addr);
            end else begin
                chk("req_addr", int'(aer_addr), exp_addr.pop_front());
            end
            if (first_req) begin
                chk("req_latency", cyc - start_cyc, 3);
                first_req = 1'b0;
            end
            if (fall_valid) begin
                chk("gap_cycles", cyc - fall_cyc, SYNC + 3 + GAP);
                fall_valid = 1'b0;
            end
        end
        if (!req && req_prev) begin
            req_fall_cyc = cyc;
            if (rise_valid) begin
                chk("req_fall_latency", cyc - rise_cyc, SYNC + 1);
                rise_valid = 1'b0;
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL done_unexpected: got done with evt_cnt %0d, expected no done", evt_cnt);
            end else begin
                chk("done_evt_cnt", int'(evt_cnt), exp_done.pop_front());
            end
            if (done_lat >= 0) chk("done_latency", cyc - start_cyc, done_lat);
        end
        req_prev = req;
    end

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num = n[AW:0];
        start_cyc = cyc;
        first_req = 1'b1;
        fall_valid = 1'b0;
        rise_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        if (n != 0) begin
            chk("rd_en_first", int'(rd_en), 1);
            chk("rd_addr_first", int'(rd_addr), 0);
        end
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("busy_idle", int'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int rd_before;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req", int'(req), 0);
        chk("rst_addr", int'(aer_addr), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_terr", int'(terr), 0);
        chk("rst_evt_cnt", int'(evt_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Burst of three
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        exp_addr.push_back('h11); exp_addr.push_back('h22); exp_addr.push_back('h33);
        exp_done.push_back(3);
        do_start(3);
        wait_idle(300);
        chk("b3_evt_cnt", int'(evt_cnt), 3);
        chk("b3_terr", int'(terr), 0);
        chk("b3_addr_hold", int'(aer_addr), 'h33);

        // Zero-length burst
        exp_done.push_back(0);
        done_lat = 1;
        rd_before = rd_cnt;
        do_start(0);
        wait_idle(10);
        done_lat = -1;
        chk("zero_no_rd_en", rd_cnt - rd_before, 0);
        chk("zero_evt_cnt", int'(evt_cnt), 0);

        // Timeout with ACK never returned
        ack_en = 1'b0;
        mem[0] = 8'h5A;
        exp_addr.push_back('h5A);
        do_start(1);
        wait_idle(100);
        chk("timeout_len", req_fall_cyc - req_rise_cyc, TMO);
        chk("timeout_err", int'(terr), 1);
        chk("timeout_evt_cnt", int'(evt_cnt), 0);
        chk("timeout_req", int'(req), 0);
        ack_en = 1'b1;
        mem[0] = 8'hA5;
        exp_addr.push_back('hA5);
        exp_done.push_back(1);
        do_start(1);
        chk("terr_cleared", int'(terr), 0);
        wait_idle(100);

        // Abort pulsed while fetching the second of five events
        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        exp_addr.push_back(1); exp_addr.push_back(2);
        exp_done.push_back(2);
        do_start(5);
        k = 0;
        while (!(rd_en && rd_addr == AW'(1)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("abort_fetch_seen", int'(rd_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle(200);
        chk("abort_evt_cnt", int'(evt_cnt), 2);

        // Abort while idle has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);

        // Full-depth burst, no wrap
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'(8'hC0 + i);
            exp_addr.push_back('hC0 + i);
        end
        exp_done.push_back(DEPTH);
        do_start(DEPTH);
        wait_idle(1000);
        chk("full_evt_cnt", int'(evt_cnt), DEPTH);

        // Reset while REQ is high
        mem[0] = 8'h77; mem[1] = 8'h88;
        exp_addr.push_back('h77);
        do_start(2);
        k = 0;
        while (!req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_req_seen", int'(req), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("amid_req", int'(req), 0);
        chk("amid_busy", int'(busy), 0);
        chk("amid_rd_en", int'(rd_en), 0);
        chk("amid_addr", int'(aer_addr), 0);
        chk("amid_evt_cnt", int'(evt_cnt), 0);
        chk("amid_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem[0] = 8'h99;
        exp_addr.push_back('h99);
        exp_done.push_back(1);
        do_start(1);
        wait_idle(100);
        chk("post_rst_evt_cnt", int'(evt_cnt), 1);

        chk("addr_queue_empty", exp_addr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
